// File: rtl/mips_pkg.sv
// mips_pkg: opcode/funct constants shared with the control path and the dmem FSM state encoding
package mips_pkg;
  localparam logic [5:0] OP_R      = 6'b000000;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic IDLE = 1'b0;
  localparam logic WAIT = 1'b1;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DW single-port data memory, synchronous write, registered read, no reset
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int DW = 32,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [IW-1:0] idx,
  input  logic [DW-1:0] wd,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [DEPTH];
  // write and read share one port; q holds its value between reads
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wd;
    if (re) q <= mem[idx];
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data memory responder with multi-cycle latency and pipeline stall; DMEM_ALIGN_CHECK_EN rejects unaligned requests
module dmem_ctrl import mips_pkg::*; #(
  parameter int DEPTH = 256,
  parameter int LATENCY = 2,
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [5:0]    op_mem,
  input  logic          w_data,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          stall,
  output logic          misalign
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  logic          state, st_q, loaded, rv, mis, bad, kind, idle, req, done, acc_st;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx_q, acc_idx;
  logic [DW-1:0] wd_q, acc_wd, q;
`ifdef DMEM_ALIGN_CHECK_EN
  assign bad = addr[1:0] != 2'b00;
`else
  assign bad = 1'b0;
`endif
  assign idle = state == IDLE;
  assign kind = w_data || op_mem == OP_LW;
  assign req = idle && kind && !bad;
  assign done = rst && (idle ? req && LATENCY == 1 : cnt == CW'(1));
  assign acc_idx = idle ? addr[IW+1:2] : idx_q;
  assign acc_wd = idle ? wdata : wd_q;
  assign acc_st = idle ? w_data : st_q;
  assign stall = rst && ((req && LATENCY > 1) || (!idle && cnt != CW'(1)));
  assign rvalid = rv;
  assign misalign = mis;
  assign rdata = loaded ? q : '0;
  dmem_array #(.DEPTH(DEPTH), .DW(DW)) u_array (
    .clk(clk),
    .we(done && acc_st),
    .re(done && !acc_st),
    .idx(acc_idx),
    .wd(acc_wd),
    .q(q)
  );
  // accept in IDLE, count down in WAIT, flag completed loads and rejected unaligned requests
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      idx_q <= '0;
      wd_q <= '0;
      st_q <= 1'b0;
      rv <= 1'b0;
      loaded <= 1'b0;
      mis <= 1'b0;
    end else begin
      rv <= done && !acc_st;
      loaded <= loaded || (done && !acc_st);
      mis <= idle && kind && bad;
      if (req && LATENCY > 1) begin
        state <= WAIT;
        cnt <= CW'(LATENCY - 1);
        idx_q <= addr[IW+1:2];
        wd_q <= wdata;
        st_q <= w_data;
      end else if (!idle) begin
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: scoreboard bench for two dmem_ctrl instances (LATENCY 2 and 4) against a word-array reference model
module tb_dmem_ctrl;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  op_mem [2];
  logic        w_data [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        rvalid [2];
  logic        stall [2];
  logic        misalign [2];
  logic [31:0] refm [2][256];
  logic [31:0] expq [2][$];
  logic [31:0] last [2];
  bit          fresh_bad [2];
  bit          prev_bad [2];
  int          checks = 0;
  int          failures = 0;

  dmem_ctrl #(.DEPTH(256), .LATENCY(2), .DW(32), .AW(32)) u2 (
    .clk(clk), .rst(rst), .op_mem(op_mem[0]), .w_data(w_data[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .rvalid(rvalid[0]), .stall(stall[0]), .misalign(misalign[0]));
  dmem_ctrl #(.DEPTH(256), .LATENCY(4), .DW(32), .AW(32)) u4 (
    .clk(clk), .rst(rst), .op_mem(op_mem[1]), .w_data(w_data[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .rvalid(rvalid[1]), .stall(stall[1]), .misalign(misalign[1]));

  always #5 clk = ~clk;

  function automatic int lat(input int k);
    return k == 0 ? 2 : 4;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s lat=%0d got=%h exp=%h t=%0t", nm, lat(k), act, exp, $time);
    end
  endtask

  task automatic idle_in(input int k);
    op_mem[k] = 6'b000000;
    w_data[k] = 1'b0;
    addr[k] = '0;
    wdata[k] = '0;
  endtask

  // one pipeline instruction in MEM: inputs held while stall is high, then removed
  task automatic access(input int k, input logic [5:0] op, input bit st, input logic [31:0] a,
                        input logic [31:0] d, input string nm);
    bit req, bad, s;
    int stalls = 0, cyc = 0;
    int w = int'((a >> 2) % 256);
    req = st || op == 6'b100011;
    bad = ALIGN && a[1:0] != 2'b00;
    op_mem[k] = op;
    w_data[k] = st;
    addr[k] = a;
    wdata[k] = d;
    fresh_bad[k] = req && bad;
    if (req && !bad) begin
      if (st) refm[k][w] = d;
      else expq[k].push_back(refm[k][w]);
    end
    forever begin
      @(negedge clk);
      s = stall[k];
      if (s) stalls++;
      cyc++;
      @(posedge clk);
      #1;
      fresh_bad[k] = 1'b0;
      if (!s) break;
      if (cyc > 20) begin
        chk({nm, "_timeout"}, k, 32'(cyc), 32'(lat(k)));
        break;
      end
    end
    chk({nm, "_stalls"}, k, 32'(stalls), (req && !bad) ? 32'(lat(k) - 1) : 32'd0);
    idle_in(k);
  endtask

  task automatic reset_outputs(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_stall"}, k, 32'(stall[k]), 32'd0);
      chk({nm, "_rvalid"}, k, 32'(rvalid[k]), 32'd0);
      chk({nm, "_rdata"}, k, rdata[k], 32'd0);
      chk({nm, "_misalign"}, k, 32'(misalign[k]), 32'd0);
    end
  endtask

  // scoreboard monitor: every completed load must pop a matching expectation
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        last[k] = '0;
        prev_bad[k] = 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (rvalid[k]) begin
          if (expq[k].size() == 0) chk("rvalid_unexpected", k, 32'd1, 32'd0);
          else begin
            last[k] = expq[k].pop_front();
            chk("load_data", k, rdata[k], last[k]);
          end
        end else chk("rdata_hold", k, rdata[k], last[k]);
        chk("misalign", k, 32'(misalign[k]), 32'(prev_bad[k]));
        prev_bad[k] = fresh_bad[k];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, d;
    int r;
    for (int k = 0; k < 2; k++) begin
      idle_in(k);
      last[k] = '0;
      fresh_bad[k] = 1'b0;
      prev_bad[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset_outputs("reset");
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      access(k, 6'b101011, 1'b1, 32'h10, 32'hDEADBEEF, "sw_10");
      access(k, 6'b100011, 1'b0, 32'h10, 32'h0, "lw_10");
      access(k, 6'b101011, 1'b1, 32'h400, 32'h5, "sw_wrap");
      access(k, 6'b100011, 1'b0, 32'h0, 32'h0, "lw_wrap");
      access(k, 6'b100011, 1'b0, 32'h13, 32'h0, "lw_13");
      access(k, 6'b001000, 1'b0, 32'h10, 32'h0, "addi_none");
      for (int i = 0; i < 16; i++) begin
        a = $urandom();
        a[5:0] = 6'(i << 2);
        access(k, 6'b101011, 1'b1, a, $urandom(), "sw_init");
      end
      for (int i = 0; i < 80; i++) begin
        a = $urandom();
        a[5:2] = 4'($urandom_range(0, 15));
        a[1:0] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        d = $urandom();
        r = $urandom_range(0, 9);
        if (r < 4) access(k, 6'b101011, 1'b1, a, d, "sw_rand");
        else if (r < 8) access(k, 6'b100011, 1'b0, a, d, "lw_rand");
        else if (r == 8) access(k, 6'($urandom_range(0, 34)), 1'b0, a, d, "other_rand");
        else access(k, 6'b100011, 1'b1, a, d, "both_rand");
        if ($urandom_range(0, 3) == 0) @(posedge clk);
        #1;
      end
    end
    op_mem[1] = 6'b101011;
    w_data[1] = 1'b1;
    addr[1] = 32'h10;
    wdata[1] = 32'hCAFEF00D;
    @(posedge clk);
    @(posedge clk);
    #1;
    idle_in(1);
    rst = 1'b0;
    #1;
    reset_outputs("mid_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    access(1, 6'b100011, 1'b0, 32'h10, 32'h0, "lw_after_abort");
    access(0, 6'b100011, 1'b0, 32'h10, 32'h0, "lw_after_reset");
    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) chk("pending_loads", k, 32'(expq[k].size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
